// File: rtl/multicycle_core_if.sv
// Data-memory ready/valid bus for multicycle_core.
// The core holds req/we/addr/wdata steady until the memory answers with ready.
interface multicycle_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle processor: FETCH/DECODE/EXECUTE/MEM/WB sequencing, one instruction per 3-5+ cycles.
// Instruction memory is combinational; data memory stalls the core through the ready handshake.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_FETCH   | latch imem_data into IR
// S_DECODE  | read operands A=R[rd], B=R[rs]; HALT opcode parks the core
// S_EXECUTE | ALU result, branch/jump pc update, or launch a memory access
// S_MEM     | hold dmem request until dmem_ready
// S_WB      | write R[rd], advance pc
// S_HALT    | terminal until reset
module multicycle_core #(
  parameter int  DATA_WIDTH = 8,
  parameter int  REG_ADDR_W = 2,
  parameter int  PC_WIDTH   = 8,
  localparam int IMM_W      = REG_ADDR_W + 3,
  localparam int INSTR_W    = 6 + 2 * REG_ADDR_W,
  localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]    imem_data,
  multicycle_core_if.master     dmem,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  retire,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000, OP_ADDI = 3'b001, OP_LW  = 3'b010, OP_SW   = 3'b011,
    OP_BEQZ = 3'b100, OP_JMP  = 3'b101, OP_LI  = 3'b110, OP_HALT = 3'b111
  } opcode_t;

  state_t                state;
  logic [INSTR_W-1:0]    ir;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q, exec_result;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  req_q, we_q, retire_q, halted_q;
  logic [PC_WIDTH-1:0]   pc_q, pc_next, imm_pc, jmp_target;

  opcode_t               op;
  logic [REG_ADDR_W-1:0] rd, rs;
  logic [2:0]            funct;
  logic [IMM_W-1:0]      imm;
  logic [DATA_WIDTH-1:0] imm_data;

  assign op         = opcode_t'(ir[INSTR_W-1 -: 3]);
  assign rd         = ir[INSTR_W-4 -: REG_ADDR_W];
  assign rs         = ir[3 +: REG_ADDR_W];
  assign funct      = ir[2:0];
  assign imm        = ir[IMM_W-1:0];
  assign imm_data   = DATA_WIDTH'($signed(imm));
  assign imm_pc     = PC_WIDTH'($signed(imm));
  // JMP target is the unsigned {rd, imm} field, fitted to the PC width
  assign jmp_target = PC_WIDTH'(ir[INSTR_W-4:0]);
  assign pc_next    = pc_q + PC_WIDTH'(1);

  always_comb begin
    exec_result = '0;
    case (op)
      OP_ALU: begin
        case (funct)
          3'b000:  exec_result = a_q + b_q;
          3'b001:  exec_result = a_q - b_q;
          3'b010:  exec_result = a_q & b_q;
          3'b011:  exec_result = a_q | b_q;
          3'b100:  exec_result = a_q ^ b_q;
          3'b101:  exec_result = DATA_WIDTH'($signed(a_q) < $signed(b_q));
          3'b110:  exec_result = ~b_q;
          default: exec_result = b_q;
        endcase
      end
      OP_ADDI: exec_result = a_q + imm_data;
      OP_LI:   exec_result = imm_data;
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q <= regs[rd];
          b_q <= regs[rs];
          if (op == OP_HALT) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state    <= S_EXECUTE;
            // control transfers finish in EXECUTE, so their retire is known now
            retire_q <= (op == OP_BEQZ) || (op == OP_JMP);
          end
        end
        S_EXECUTE: begin
          case (op)
            OP_BEQZ: begin
              pc_q  <= (a_q == '0) ? pc_next + imm_pc : pc_next;
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc_q  <= jmp_target;
              state <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              req_q   <= 1'b1;
              we_q    <= (op == OP_SW);
              addr_q  <= b_q;
              wdata_q <= a_q;
              state   <= S_MEM;
            end
            default: begin
              result_q <= exec_result;
              retire_q <= 1'b1;
              state    <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem.ready) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (op == OP_LW) begin
              result_q <= dmem.rdata;
              retire_q <= 1'b1;
              state    <= S_WB;
            end else begin
              pc_q  <= pc_next;
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          regs[rd] <= result_q;
          pc_q     <= pc_next;
          state    <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // a store retires on its ready cycle, which cannot be known a cycle early
  assign retire     = retire_q | ((state == S_MEM) && dmem.ready && (op == OP_SW));
  assign halted     = halted_q;
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign dbg_data   = regs[dbg_sel];
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed-program bench for multicycle_core: an instruction-level model predicts
// pc, register contents, retire timing and memory traffic for every cycle.
module tb_multicycle_core;

  localparam logic [2:0] ALU = 3'd0, ADDI = 3'd1, LW = 3'd2, SW = 3'd3;
  localparam logic [2:0] BEQZ = 3'd4, JMP = 3'd5, LI = 3'd6, HLT = 3'd7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // default-size core
  multicycle_core_if #(.DATA_WIDTH(8)) bus ();
  logic [7:0] imem_addr, pc, dbg_data;
  logic [9:0] imem_data;
  logic [1:0] dbg_sel = 2'd0;
  logic       retire, halted;
  logic [9:0] imem [256];
  assign imem_data = imem[imem_addr];

  multicycle_core #(.DATA_WIDTH(8), .REG_ADDR_W(2), .PC_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem(bus), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
    .retire(retire), .halted(halted));

  // wide core: 8 registers, 16-bit data
  multicycle_core_if #(.DATA_WIDTH(16)) bus2 ();
  logic [7:0]  imem_addr2, pc2;
  logic [11:0] imem_data2;
  logic [2:0]  dbg_sel2 = 3'd7;
  logic [15:0] dbg_data2;
  logic        retire2, halted2;
  logic [11:0] imem2 [256];
  assign imem_data2 = imem2[imem_addr2];

  multicycle_core #(.DATA_WIDTH(16), .REG_ADDR_W(3), .PC_WIDTH(8)) dut2 (
    .clock(clock), .reset(reset), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .dmem(bus2), .dbg_sel(dbg_sel2), .dbg_data(dbg_data2), .pc(pc2),
    .retire(retire2), .halted(halted2));

  int n_err = 0, n_checks = 0;
  int mem_wait = 0;
  int first_halt, req_cycles;
  int retire_log[$];
  logic [7:0] pc_trace[$];
  logic [7:0] tb_mem [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic [7:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] e_r(input logic [2:0] op, input int rd, input int rs,
                                     input logic [2:0] f);
    return {op, rd[1:0], rs[1:0], f};
  endfunction
  function automatic logic [9:0] e_i(input logic [2:0] op, input int rd, input int imm);
    return {op, rd[1:0], imm[4:0]};
  endfunction
  function automatic logic [9:0] e_j(input int t);
    return {JMP, t[6:0]};
  endfunction
  function automatic int ret_at(input int i);
    return (i < retire_log.size()) ? retire_log[i] : -1;
  endfunction

  task automatic clear_prog(input logic [9:0] fill);
    for (int i = 0; i < 256; i++) begin
      imem[i] = fill;
      tb_mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
  endtask

  task automatic set_mem(input int a, input logic [7:0] v);
    tb_mem[a] = v;
    m_mem[a] = v;
  endtask

  task automatic peek(input string name, input int r, input logic [7:0] exp);
    dbg_sel = 2'(r);
    #1;
    chk(name, dbg_data, exp);
  endtask

  // memory responder: ready after mem_wait low cycles of a request
  initial begin
    int cnt;
    cnt = 0;
    bus.ready = 1'b0;
    bus.rdata = 8'h00;
    bus2.ready = 1'b0;
    bus2.rdata = 16'h0000;
    forever begin
      @(negedge clock);
      if (bus.req === 1'b1) begin
        if (cnt == mem_wait) begin
          bus.ready = 1'b1;
          bus.rdata = tb_mem[bus.addr];
          if (bus.we) tb_mem[bus.addr] = bus.wdata;
          cnt = 0;
        end else begin
          bus.ready = 1'b0;
          bus.rdata = 8'hEE;
          cnt++;
        end
      end else begin
        bus.ready = 1'b0;
        bus.rdata = 8'hEE;
        cnt = 0;
      end
    end
  end

  // Reset, then step the architectural model one instruction at a time,
  // comparing DUT outputs on every cycle.
  task automatic run_prog(input int budget, input int abort_at, input bit expect_halt);
    int c, cyc, L, nmem, rd, rs;
    logic [9:0] ins;
    logic [2:0] op, f;
    logic [7:0] imm8, a, b, res;
    bit is_halt, is_mem, exp_req, done;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00;
    retire_log.delete();
    pc_trace.delete();
    first_halt = 0;
    req_cycles = 0;
    nmem = mem_wait + 1;
    L = 0; rd = 0; rs = 0; op = HLT; f = 3'd0; imm8 = 8'h00; a = 8'h00; b = 8'h00;
    is_halt = 1'b0; is_mem = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    c = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clock);
      cyc++; c++;
      if (c == 1) begin
        ins = imem[m_pc];
        op = ins[9:7]; rd = int'(ins[6:5]); rs = int'(ins[4:3]); f = ins[2:0];
        imm8 = {{3{ins[4]}}, ins[4:0]};
        a = m_r[rd]; b = m_r[rs];
        is_halt = (op == HLT);
        is_mem = (op == LW) || (op == SW);
        case (op)
          HLT:       L = 0;
          BEQZ, JMP: L = 3;
          LW:        L = 4 + nmem;
          SW:        L = 3 + nmem;
          default:   L = 4;
        endcase
      end
      dbg_sel = 2'(cyc % 4);
      #1;
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("retire", retire, (c == L));
      chk("halted", halted, (is_halt && c >= 3));
      exp_req = is_mem && c >= 4 && c <= 3 + nmem;
      chk("dmem_req", bus.req, exp_req);
      if (exp_req) begin
        chk("dmem_we", bus.we, (op == SW));
        chk("dmem_addr", bus.addr, b);
        chk("dmem_wdata", bus.wdata, a);
      end
      chk("dbg_data", dbg_data, m_r[dbg_sel]);
      pc_trace.push_back(pc);
      if (retire === 1'b1) retire_log.push_back(cyc);
      if (halted === 1'b1 && first_halt == 0) first_halt = cyc;
      if (bus.req === 1'b1) req_cycles++;

      if (cyc == abort_at) begin
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        #1;
        chk("abort_req", bus.req, 1'b0);
        chk("abort_pc", pc, 8'h00);
        chk("abort_retire", retire, 1'b0);
        chk("abort_halted", halted, 1'b0);
        for (int i = 0; i < 4; i++) peek("abort_reg", i, 8'h00);
        done = 1'b1;
      end else begin
        if (L != 0 && c == L) begin
          res = 8'h00;
          case (op)
            ALU: begin
              case (f)
                3'd0: res = a + b;
                3'd1: res = a - b;
                3'd2: res = a & b;
                3'd3: res = a | b;
                3'd4: res = a ^ b;
                3'd5: res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
                3'd6: res = ~b;
                default: res = b;
              endcase
              m_r[rd] = res;
            end
            ADDI: m_r[rd] = a + imm8;
            LW:   m_r[rd] = m_mem[b];
            SW:   m_mem[b] = a;
            LI:   m_r[rd] = imm8;
            default: ;
          endcase
          if (op == BEQZ)     m_pc = (a == 8'h00) ? m_pc + 8'd1 + imm8 : m_pc + 8'd1;
          else if (op == JMP) m_pc = {1'b0, ins[6:0]};
          else                m_pc = m_pc + 8'd1;
          c = 0;
        end
        if (is_halt && c >= 5) done = 1'b1;
        if (!done && cyc >= budget) begin
          if (expect_halt) chk("halt_before_budget", halted, 1'b1);
          else chk("spin_not_halted", halted, 1'b0);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int wraps;
    for (int i = 0; i < 256; i++) imem2[i] = 12'hE00;
    imem2[0] = 12'hDFF;   // LI r7,-1
    imem2[1] = 12'h5B8;   // LW r6,(r7)

    // P1: LI/LI/ADD/HALT with retire and halt timing
    clear_prog(e_r(HLT, 0, 0, 0));
    mem_wait = 0;
    imem[0] = e_i(LI, 1, 5);
    imem[1] = e_i(LI, 2, -3);
    imem[2] = e_r(ALU, 1, 2, 3'd0);
    run_prog(100, -1, 1'b1);
    peek("p1_r1", 1, 8'h02);
    peek("p1_r2", 2, 8'hFD);
    chk("p1_retire0", ret_at(0), 4);
    chk("p1_retire1", ret_at(1), 8);
    chk("p1_retire2", ret_at(2), 12);
    chk("p1_nretire", retire_log.size(), 3);
    chk("p1_halt_cycle", first_halt, 15);
    chk("p1_pc", pc, 8'h03);

    // P2: ADDI wrap, signed SLT, SUB wrap
    clear_prog(e_r(HLT, 0, 0, 0));
    imem[0] = e_i(LI, 0, 0);
    imem[1] = e_i(ADDI, 0, -1);
    imem[2] = e_r(ALU, 0, 1, 3'd5);
    imem[3] = e_i(LI, 2, 0);
    imem[4] = e_i(LI, 3, 1);
    imem[5] = e_r(ALU, 2, 3, 3'd1);
    run_prog(100, -1, 1'b1);
    peek("p2_r0_slt", 0, 8'h01);
    peek("p2_r2_sub", 2, 8'hFF);
    peek("p2_r3", 3, 8'h01);

    // P2b: logic ops, NOT, MOV, SLT with negative left operand, ADDI
    clear_prog(e_r(HLT, 0, 0, 0));
    imem[0] = e_i(LI, 1, 12);
    imem[1] = e_i(LI, 3, 10);
    imem[2] = e_r(ALU, 3, 1, 3'd4);
    imem[3] = e_r(ALU, 1, 3, 3'd3);
    imem[4] = e_r(ALU, 1, 3, 3'd2);
    imem[5] = e_r(ALU, 0, 1, 3'd6);
    imem[6] = e_r(ALU, 2, 0, 3'd7);
    imem[7] = e_r(ALU, 2, 3, 3'd5);
    imem[8] = e_i(ADDI, 1, 15);
    run_prog(100, -1, 1'b1);
    peek("p2b_r0", 0, 8'hF9);
    peek("p2b_r1", 1, 8'h15);
    peek("p2b_r2", 2, 8'h01);
    peek("p2b_r3", 3, 8'h06);

    // P3: slow memory, LW then SW then LW back
    clear_prog(e_r(HLT, 0, 0, 0));
    mem_wait = 3;
    set_mem(8'h10, 8'hA5);
    imem[0]  = e_i(LI, 2, 8);
    imem[1]  = e_r(ALU, 2, 2, 3'd0);
    imem[2]  = e_r(LW, 1, 2, 3'd0);
    imem[3]  = e_i(LI, 3, 8);
    imem[4]  = e_r(ALU, 3, 3, 3'd0);
    imem[5]  = e_r(ALU, 3, 3, 3'd0);
    imem[6]  = e_i(LI, 0, 15);
    imem[7]  = e_r(ALU, 0, 0, 3'd0);
    imem[8]  = e_r(ALU, 0, 0, 3'd0);
    imem[9]  = e_r(SW, 0, 3, 3'd0);
    imem[10] = e_r(LW, 2, 3, 3'd0);
    run_prog(200, -1, 1'b1);
    peek("p3_r1_load", 1, 8'hA5);
    peek("p3_r2_reload", 2, 8'h3C);
    peek("p3_r3", 3, 8'h20);
    chk("p3_lw_retire", ret_at(2), 16);
    chk("p3_sw_retire", ret_at(9), 47);
    chk("p3_req_cycles", req_cycles, 12);
    chk("p3_mem_store", tb_mem[8'h20], 8'h3C);

    // P3b: zero-wait memory
    clear_prog(e_r(HLT, 0, 0, 0));
    mem_wait = 0;
    imem[0] = e_i(LI, 1, 7);
    imem[1] = e_i(LI, 2, 5);
    imem[2] = e_r(SW, 1, 2, 3'd0);
    imem[3] = e_r(LW, 3, 2, 3'd0);
    run_prog(100, -1, 1'b1);
    peek("p3b_r3", 3, 8'h07);
    chk("p3b_sw_retire", ret_at(2), 12);
    chk("p3b_lw_retire", ret_at(3), 17);

    // P4: taken/not-taken BEQZ, JMP high, run to 0xFE and wrap to 0
    clear_prog(e_i(BEQZ, 0, 0));
    imem[0]     = e_i(BEQZ, 3, 6);
    imem[1]     = e_r(HLT, 0, 0, 0);
    imem[7]     = e_i(LI, 1, 1);
    imem[8]     = e_i(BEQZ, 1, 5);
    imem[9]     = e_i(BEQZ, 0, 3);
    imem[13]    = e_i(LI, 3, 5);
    imem[14]    = e_j(127);
    imem[8'hFE] = e_i(BEQZ, 0, 1);
    run_prog(600, -1, 1'b1);
    wraps = 0;
    for (int i = 0; i + 1 < pc_trace.size(); i++)
      if (pc_trace[i] == 8'hFE && pc_trace[i+1] == 8'h00) wraps++;
    chk("p4_wrap_seen", wraps, 1);
    chk("p4_nretire", retire_log.size(), 135);
    chk("p4_pc", pc, 8'h01);
    peek("p4_r3", 3, 8'h05);

    // P5: JMP 7 then self-loop spin
    clear_prog(e_r(HLT, 0, 0, 0));
    imem[0] = e_j(7);
    imem[7] = e_j(7);
    run_prog(40, -1, 1'b0);
    chk("p5_pc_cycle4", (pc_trace.size() > 3) ? pc_trace[3] : 8'hXX, 8'h07);
    chk("p5_nretire", retire_log.size(), 13);
    chk("p5_pc", pc, 8'h07);

    // P5b: BEQZ imm=-1 spin
    clear_prog(e_r(HLT, 0, 0, 0));
    imem[0] = e_i(BEQZ, 0, -1);
    run_prog(12, -1, 1'b0);
    chk("p5b_nretire", retire_log.size(), 4);
    chk("p5b_pc", pc, 8'h00);

    // P6: reset while a load waits on memory
    clear_prog(e_r(HLT, 0, 0, 0));
    mem_wait = 1000;
    imem[0] = e_i(LI, 1, 7);
    imem[1] = e_i(LI, 2, 3);
    imem[2] = e_r(LW, 0, 2, 3'd0);
    run_prog(100, 14, 1'b0);

    // wide core: LI r7,-1 then a load that never completes, aborted by reset
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      #1;
      if (i == 4) chk("w_retire_li", retire2, 1'b1);
    end
    chk("w_r7", dbg_data2, 16'hFFFF);
    chk("w_req", bus2.req, 1'b1);
    chk("w_addr", bus2.addr, 16'hFFFF);
    chk("w_we", bus2.we, 1'b0);
    chk("w_pc", pc2, 8'h01);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1;
    chk("w_abort_req", bus2.req, 1'b0);
    chk("w_abort_pc", pc2, 8'h00);
    chk("w_abort_r7", dbg_data2, 16'h0000);
    chk("w_abort_halted", halted2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the team's single-cycle 8-bit processor. It executes one instruction every 3–5 cycles through a fetch/decode/execute/memory/writeback FSM. Data width and register count are configurable, and data memory sits behind a ready/valid handshake so slow memories stall the core. Instruction memory stays external and combinational. A debug read port and a retire pulse give the bench architectural visibility.

## Interface
- `DATA_WIDTH`, 8: register/ALU/data-memory word width (≥4).
- `REG_ADDR_W`, 2: register index width; `2**REG_ADDR_W` registers.
- `PC_WIDTH`, 8: PC/instruction-address width.
- Derived: `IMM_W = REG_ADDR_W+3`; `INSTR_W = 6+2*REG_ADDR_W`. Fields, MSB first:
  - opcode[3]
  - rd[REG_ADDR_W]
  - rs[REG_ADDR_W]
  - funct[3]
  - I-type: imm = {rs,funct}.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out PC_WIDTH: equals `pc`.
- `imem_data` in INSTR_W: combinational read of `imem_addr`.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out DATA_WIDTH: access address.
- `dmem_wdata` out DATA_WIDTH: store data.
- `dmem_ready` in 1: access complete this cycle.
- `dmem_rdata` in DATA_WIDTH: load data, valid when `dmem_ready`=1.
- `dbg_sel` in REG_ADDR_W: debug register select.
- `dbg_data` out DATA_WIDTH: combinational `R[dbg_sel]`.
- `pc` out PC_WIDTH: current PC.
- `retire` out 1: one-cycle pulse on an instruction's final cycle.
- `halted` out 1: core in HALT.

## Operation
- Opcodes; sext = sign-extend imm:
  - 000 ALU: `R[rd] = R[rd] op R[rs]`. funct: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 NOT R[rs], 111 MOV R[rs].
  - 001 ADDI: `R[rd] += sext(imm)`.
  - 010 LW: `R[rd] = mem[R[rs]]`.
  - 011 SW: `mem[R[rs]] = R[rd]`.
  - 100 BEQZ: if `R[rd]==0`, `pc = pc+1+sext(imm)`; else `pc+1`.
  - 101 JMP: `pc = zero-extended {rd,imm}`, truncated/extended to PC_WIDTH.
  - 110 LI: `R[rd] = sext(imm)`.
  - 111 HALT.
- Arithmetic is modulo 2^DATA_WIDTH, no flags. PC arithmetic is modulo 2^PC_WIDTH, so PC wraps.
- FSM states and transitions:
  - FETCH: IR ← imem_data; go to DECODE.
  - DECODE: A ← R[rd], B ← R[rs]. HALT opcode goes to HALT; otherwise EXECUTE.
  - EXECUTE:
    - ALU/ADDI/LI: result computed; go to WB.
    - BEQZ/JMP: pc updated, retire; go to FETCH.
    - LW/SW: go to MEM.
  - MEM: `dmem_req`=1; `dmem_addr`=B, `dmem_wdata`=A, `dmem_we`=(op==SW), all stable until ready. While `dmem_ready`=0, stay. When 1: LW captures rdata and goes to WB; SW sets pc+1, retires, goes to FETCH.
  - WB: write R[rd], pc+1, retire; go to FETCH.
  - HALT: terminal until reset. `halted`=1, pc frozen, no memory requests.
- Register file writes only in WB. In every other state `dmem_req`=0, `dmem_we`=0.
- Reset values: all registers 0, pc 0, state FETCH, `dmem_req`/`dmem_we`/`retire`/`halted` 0, `dmem_addr`/`dmem_wdata` 0.

## Timing
- Latency: ALU/ADDI/LI 4 cycles; BEQZ/JMP 3 cycles; LW 4+N; SW 3+N, where N ≥ 1 is MEM cycles up to and including the `dmem_ready` cycle.
- `retire` is high exactly one cycle per instruction: the last cycle before returning to FETCH. HALT never pulses `retire`.
- `dmem_ready` is sampled only in MEM; it is ignored elsewhere.
- Reset mid-operation: `reset` high at an edge forces reset values at that edge regardless of state. A pending MEM request drops, with no register write and no retire.
- `dbg_data` reflects WB writes from the cycle after WB.
- A self-loop JMP to the same pc or a BEQZ with imm=−1 is legal; it spins without halting.

## Test plan
- Reset; program LI r1,5; LI r2,−3; ALU ADD r1,r2; HALT → r1=2, r2=0xFD. `retire` pulses at cycles 4, 8, 12. `halted`=1 at cycle 15 and pc=3 thereafter.
- LI r0,0; ADDI r0,−1; ALU SLT r0,r1 with r1=0 → r0 goes 0xFF then 1. SUB 0−1 → 0xFF, checking wrap.
- LW r1,(r2) with r2=0x10, `dmem_ready` held low 3 cycles then high with rdata 0xA5 → `dmem_req` high 4 cycles, addr stable at 0x10, `we`=0. r1=0xA5; retire on the WB cycle.
- SW with r0=0x3C, r3=0x20 → `req`=1, `we`=1, addr 0x20, wdata 0x3C until ready. No register changes.
- BEQZ taken at pc=0xFE with imm=+1 → pc=0x00 (wrap). Not-taken → pc+1. JMP to 0x07 → pc=0x07 after 3 cycles.
- Assert `reset` during MEM wait → next cycle `dmem_req`=0, pc=0, all registers 0, state FETCH. Repeat with REG_ADDR_W=3, DATA_WIDTH=16: LI r7,−1 → 0xFFFF.
